// File: rtl/arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant selector and default watchdog limit.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } arb_grant_t;

    localparam int TIMEOUT = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Counts busy cycles without a memory acknowledge; flags expiry once the count reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT so an abandoned count cannot wrap back to a quiet value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for a single-port unified memory; data wins ties, grants alternate under contention.
// Optional watchdog abort on a missing mem_ack is enabled by defining ARB_TIMEOUT_EN.
module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = arb_pkg::TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             stall_F,
    output logic             stall_M,
    output logic             err
);

    arb_state_t state, state_next;
    arb_grant_t grant_sel;
    logic       grant;
    logic       busy;
    logic       expired;
    logic       timed_out;
    logic       done;

    assign busy      = (state != IDLE);
    assign timed_out = busy & ~mem_ack & expired;
    assign done      = busy & (mem_ack | expired);

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .enable  (busy & ~mem_ack),
        .expired (expired)
    );
`else
    // Without the watchdog a transaction never expires; the comparison is always false.
    assign expired = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The served requester's req is ignored in its completion cycle, which forces alternation.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_sel  = GNT_IF;
        case (state)
            IDLE: begin
                if (d_req) begin
                    state_next = BUSY_D;
                    grant      = 1'b1;
                    grant_sel  = GNT_D;
                end else if (if_req) begin
                    state_next = BUSY_IF;
                    grant      = 1'b1;
                    grant_sel  = GNT_IF;
                end
            end
            BUSY_IF: begin
                if (done) begin
                    if (d_req) begin
                        state_next = BUSY_D;
                        grant      = 1'b1;
                        grant_sel  = GNT_D;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            BUSY_D: begin
                if (done) begin
                    if (if_req) begin
                        state_next = BUSY_IF;
                        grant      = 1'b1;
                        grant_sel  = GNT_IF;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant) begin
            if (grant_sel == GNT_D) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    assign mem_req  = busy & ~timed_out;
    assign err      = timed_out;
    assign if_ready = (state == BUSY_IF) & done;
    assign d_ready  = (state == BUSY_D) & done;
    // An aborted transaction returns zero data, hence the gating on mem_ack rather than on ready.
    assign if_rdata = ((state == BUSY_IF) && mem_ack) ? mem_rdata : '0;
    assign d_rdata  = ((state == BUSY_D) && mem_ack) ? mem_rdata : '0;
    assign stall_F  = if_req & ~if_ready;
    assign stall_M  = d_req & ~d_ready;

endmodule
